uart_rx_ctrl: RTL

Receive-side controller for the UART. It sequences the RX datapath: start-bit validation, oversampled mid-bit sampling, LSB-first data shift, parity check and stop check. Each completed byte goes into a one-entry holding register with a valid/ready handshake, together with error status. It sits between the line synchronizer/baud generator and the host-side consumer.

---
 rtl/uart_rx_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer.
// Validates the start bit at mid-bit and samples each following bit once per
// bit period, LSB first. It then checks parity and the stop bit, and hands each
// completed frame to a one-entry valid/ready holding register with error flags.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam int             SW       = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0]  S_MID    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]  S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_RECOVER
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [SW-1:0]        r_s_cnt;
  logic [2:0]           r_b_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_parity_error;
  logic                 r_framing_error;
  logic                 r_overrun_error;

  logic                 w_busy;
  logic                 w_mid;       // start-bit midpoint tick
  logic                 w_sample;    // mid-bit sample tick in DATA/PARITY/STOP
  logic                 w_data_smp;
  logic                 w_par_smp;
  logic                 w_stop_smp;
  logic                 w_load;
  logic                 w_drop;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; every transition is gated by baud_tick.
  always_comb begin
    w_next = r_state;
    if (baud_tick) begin
      unique case (r_state)
        S_IDLE:    if (!rx_in) w_next = S_START;
        S_START:   if (r_s_cnt == S_MID) w_next = rx_in ? S_IDLE : S_DATA;
        S_DATA:    if (r_s_cnt == S_LAST && r_b_cnt == LAST_BIT)
                     w_next = PARITY_EN ? S_PARITY : S_STOP;
        S_PARITY:  if (r_s_cnt == S_LAST) w_next = S_STOP;
        S_STOP:    if (r_s_cnt == S_LAST) w_next = rx_in ? S_IDLE : S_RECOVER;
        S_RECOVER: if (rx_in) w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Decoded strobes for the datapath and the busy output.
  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_mid      = baud_tick && (r_state == S_START) && (r_s_cnt == S_MID);
    w_sample   = baud_tick && (r_s_cnt == S_LAST) &&
                 ((r_state == S_DATA) || (r_state == S_PARITY) || (r_state == S_STOP));
    w_data_smp = w_sample && (r_state == S_DATA);
    w_par_smp  = w_sample && (r_state == S_PARITY);
    w_stop_smp = w_sample && (r_state == S_STOP);
    w_load     = w_stop_smp && (!r_rx_valid || rx_ready);
    w_drop     = w_stop_smp && r_rx_valid && !rx_ready;
  end

  // Sample and bit counters; they restart at every sample point and idle at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s_cnt <= '0;
      r_b_cnt <= '0;
    end else if (baud_tick) begin
      if (!w_busy || r_state == S_RECOVER || w_mid || w_sample) r_s_cnt <= '0;
      else                                                      r_s_cnt <= r_s_cnt + 1'b1;
      if (w_mid)           r_b_cnt <= '0;
      else if (w_data_smp) r_b_cnt <= r_b_cnt + 1'b1;
    end
  end

  // Shift data in LSB first (after DATA_BITS right shifts bit 0 sits at the LSB)
  // and evaluate parity against the data collected so far.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift <= '0;
      r_perr  <= 1'b0;
    end else begin
      if (w_mid)      r_perr  <= 1'b0;
      if (w_data_smp) r_shift <= {rx_in, r_shift[DATA_BITS-1:1]};
      if (w_par_smp)  r_perr  <= (((^r_shift) ^ rx_in) != PARITY_ODD);
    end
  end

  // Holding register: load on the stop sample unless full and not being drained.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_data       <= '0;
      r_rx_valid      <= 1'b0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun_error <= 1'b0;
    end else begin
      r_overrun_error <= w_drop;
      if (w_load) begin
        r_rx_data       <= r_shift;
        r_parity_error  <= r_perr;
        r_framing_error <= !rx_in;
        r_rx_valid      <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid      <= 1'b0;
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign parity_error  = r_parity_error;
  assign framing_error = r_framing_error;
  assign overrun_error = r_overrun_error;
  assign busy          = w_busy;

endmodule
